fpu_add_sub_seq: RTL and testbench
==================================

FPU_ADD_SUB_SEQ -- requirements
Module: fpu_add_sub_seq

Interface
REQ-001 Parameter NORM_MAX, default 24, is the maximum number of NORM cycles before a forced exit.
REQ-002 clk_i  in  1  single clock; all state changes on the rising edge.
REQ-003 reset_i  in  1  asynchronous, active-low reset.
REQ-004 req_valid_i  in  1  add/sub request present.
REQ-005 req_ready_o  out  1  block can accept a request (high only in IDLE).
REQ-006 sub_i  in  1  1 = subtract, 0 = add.
REQ-007 rm_i  in  3  instruction rounding-mode field.
REQ-008 frm_i  in  3  dynamic rounding mode from the frm CSR.
REQ-009 flush_i  in  1  kill the in-flight operation.
REQ-010 norm_done_i  in  1  datapath reports the mantissa is normalized.
REQ-011 align_en_o, add_en_o, norm_en_o, round_en_o  out  1 each  one-hot datapath stage enables.
REQ-012 rm_o  out  3  resolved rounding mode driven to the rounder.
REQ-013 sub_o  out  1  latched operation.
REQ-014 res_valid_o  out  1  result/flags valid.
REQ-015 res_ready_i  in  1  consumer accepts the result.
REQ-016 illegal_o  out  1  rounding mode illegal; valid with res_valid_o.
REQ-017 busy_o  out  1  state is not IDLE.

Function
REQ-018 States SHALL be IDLE, ALIGN, ADD, NORM, ROUND, DONE.
REQ-019 Accept on req_valid_i & req_ready_o:
- latch sub_i and the resolved mode into rm_o;
- latch illegal into illegal_o.
REQ-020 Mode resolution:
- rm_i = 3'b111 (DYN) selects frm_i;
- otherwise rm_i is used;
- a resolved value of 101, 110 or 111 is illegal.
REQ-021 Legal accept goes IDLE->ALIGN; illegal accept goes IDLE->DONE directly with no stage enable asserted.
REQ-022 ALIGN->ADD->NORM, one cycle each.
REQ-023 NORM loop:
- stay in NORM while norm_done_i = 0;
- go to ROUND in the cycle after norm_done_i = 1 is sampled;
- a 5-bit counter cleared on NORM entry counts NORM cycles;
- when the counter reaches NORM_MAX-1, go to ROUND regardless of norm_done_i.
REQ-024 ROUND->DONE after one cycle.
REQ-025 In DONE, res_valid_o = 1:
- hold state and all latched outputs until res_ready_i = 1;
- then go to IDLE.
REQ-026 Exactly one stage enable is high in its matching state; all enables are low in IDLE and DONE.
REQ-027 Minimum legal latency: accept in cycle T, res_valid_o high in T+5 when norm_done_i = 1 in the first NORM cycle (T+3).
REQ-028 flush_i in any state other than IDLE:
- forces IDLE on the next edge;
- deasserts res_valid_o and illegal_o;
- takes priority over every other transition, including DONE handshake completion.
REQ-029 flush_i in IDLE is ignored, and no request is accepted in that cycle.
REQ-030 No new request is accepted in the DONE->IDLE cycle; req_ready_o rises the cycle after.
REQ-031 rm_o and sub_o SHALL stay stable from accept until IDLE is re-entered.

Reset
REQ-032 On reset_i = 0, asynchronously:
- state = IDLE, NORM counter = 0;
- rm_o = 000, sub_o = 0, illegal_o = 0, res_valid_o = 0, all enables = 0.
REQ-033 On reset_i = 0: req_ready_o = 1 and busy_o = 0.
REQ-034 Reset mid-operation abandons the operation with no res_valid_o pulse.

Structure
REQ-035 The shared FPU package SHALL hold:
- the rounding-mode encodings RNE = 000, RTZ = 001, RDN = 010, RUP = 011, RMM = 100, DYN = 111;
- the state encoding.
REQ-036 Mode resolution and the legality check SHALL be one combinational sub-module, fpu_rm_resolve, reusable by the other FPU sequencers.
REQ-037 State and counter SHALL be single registers; outputs SHALL be decoded from state plus the latched registers.

Verification
REQ-038 Legal request: rm_i = 000, sub_i = 1, norm_done_i = 1 always, res_ready_i = 1 -> enables pulse T+1..T+4 in order, res_valid_o at T+5, rm_o = 000, sub_o = 1.
REQ-039 DYN request: rm_i = 111, frm_i = 011 -> rm_o = 011, illegal_o = 0; with frm_i = 101 -> illegal_o = 1, res_valid_o at T+1, no enables.
REQ-040 norm_done_i held 0 -> exactly NORM_MAX (24) NORM cycles, then ROUND; norm_done_i high on the 3rd NORM cycle -> 3 NORM cycles.
REQ-041 Back-pressure: res_ready_i low for 4 cycles in DONE -> res_valid_o, rm_o and illegal_o held; req_ready_o stays 0.
REQ-042 flush_i in NORM, and flush_i in DONE with res_ready_i = 1 -> IDLE next cycle, no further enables, res_valid_o = 0.
REQ-043 reset_i pulsed low asynchronously mid-ADD -> all outputs at reset values immediately; the next request completes normally.

Source files
------------

// File: rtl/fpu_add_sub_seq_pkg.sv
// Shared FPU definitions: rounding-mode encodings and the add/sub sequencer state encoding.
package fpu_add_sub_seq_pkg;

    localparam logic [2:0] RmRne = 3'b000;
    localparam logic [2:0] RmRtz = 3'b001;
    localparam logic [2:0] RmRdn = 3'b010;
    localparam logic [2:0] RmRup = 3'b011;
    localparam logic [2:0] RmRmm = 3'b100;
    localparam logic [2:0] RmDyn = 3'b111;

    localparam int unsigned NormCntW = 5;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StAlign = 3'd1,
        StAdd   = 3'd2,
        StNorm  = 3'd3,
        StRound = 3'd4,
        StDone  = 3'd5
    } state_e;

endpackage

// File: rtl/fpu_rm_resolve.sv
// Resolves the instruction rounding mode against frm and flags reserved encodings.
module fpu_rm_resolve
    import fpu_add_sub_seq_pkg::*;
(
    input  logic [2:0] rm_i,
    input  logic [2:0] frm_i,
    output logic [2:0] rm_o,
    output logic       illegal_o
);

    // DYN defers to the CSR; anything above RMM (101..111) is reserved.
    always_comb begin
        rm_o      = (rm_i == RmDyn) ? frm_i : rm_i;
        illegal_o = (rm_o > RmRmm);
    end

endmodule

// File: rtl/fpu_add_sub_seq.sv
// Sequencer for the FPU add/sub datapath: ALIGN -> ADD -> NORM (loop) -> ROUND -> DONE.
module fpu_add_sub_seq
    import fpu_add_sub_seq_pkg::*;
#(
    parameter int unsigned NORM_MAX = 24
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic       sub_i,
    input  logic [2:0] rm_i,
    input  logic [2:0] frm_i,
    input  logic       flush_i,
    input  logic       norm_done_i,
    output logic       align_en_o,
    output logic       add_en_o,
    output logic       norm_en_o,
    output logic       round_en_o,
    output logic [2:0] rm_o,
    output logic       sub_o,
    output logic       res_valid_o,
    input  logic       res_ready_i,
    output logic       illegal_o,
    output logic       busy_o
);

    localparam logic [NormCntW-1:0] NormLast = NormCntW'(NORM_MAX - 1);

    state_e                r_state;
    state_e                w_state_next;
    logic [NormCntW-1:0]   r_norm_cnt;
    logic [NormCntW-1:0]   w_norm_cnt_next;
    logic [2:0]            r_rm;
    logic                  r_sub;
    logic                  r_illegal;
    logic [2:0]            w_rm_res;
    logic                  w_illegal;
    logic                  w_accept;

    fpu_rm_resolve u_rm_resolve (
        .rm_i      (rm_i),
        .frm_i     (frm_i),
        .rm_o      (w_rm_res),
        .illegal_o (w_illegal)
    );

    // A flush in IDLE blocks acceptance for that cycle.
    assign w_accept = req_valid_i & req_ready_o & ~flush_i;

    // Next-state and NORM counter; flush outranks every other transition.
    always_comb begin
        w_state_next    = r_state;
        w_norm_cnt_next = r_norm_cnt;
        if (flush_i && (r_state != StIdle)) begin
            w_state_next = StIdle;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        w_state_next = w_illegal ? StDone : StAlign;
                    end
                end
                StAlign: w_state_next = StAdd;
                StAdd: begin
                    w_state_next    = StNorm;
                    w_norm_cnt_next = '0;
                end
                StNorm: begin
                    if (norm_done_i || (r_norm_cnt == NormLast)) begin
                        w_state_next = StRound;
                    end else begin
                        w_norm_cnt_next = r_norm_cnt + 1'b1;
                    end
                end
                StRound: w_state_next = StDone;
                StDone: begin
                    if (res_ready_i) begin
                        w_state_next = StIdle;
                    end
                end
                default: w_state_next = StIdle;
            endcase
        end
    end

    // State, counter and the operation fields captured at accept.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state    <= StIdle;
            r_norm_cnt <= '0;
            r_rm       <= RmRne;
            r_sub      <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_norm_cnt <= w_norm_cnt_next;
            if (w_accept) begin
                r_rm      <= w_rm_res;
                r_sub     <= sub_i;
                r_illegal <= w_illegal;
            end
        end
    end

    // Outputs decoded purely from state and latched fields.
    always_comb begin
        req_ready_o = (r_state == StIdle);
        busy_o      = (r_state != StIdle);
        align_en_o  = (r_state == StAlign);
        add_en_o    = (r_state == StAdd);
        norm_en_o   = (r_state == StNorm);
        round_en_o  = (r_state == StRound);
        res_valid_o = (r_state == StDone);
        illegal_o   = r_illegal & (r_state == StDone);
        rm_o        = r_rm;
        sub_o       = r_sub;
    end

endmodule

// File: tb/tb_fpu_add_sub_seq.sv
// Self-checking bench for fpu_add_sub_seq against a cycle-timeline reference model.
module tb_fpu_add_sub_seq;

    localparam int unsigned NormMax = 24;

    typedef struct packed {
        logic [3:0] en;    // {align, add, norm, round}
        logic       vld;
        logic       ill;
        logic [2:0] rm;
        logic       sub;
        logic       rdy;
        logic       busy;
    } obs_t;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       req_valid_i;
    logic       req_ready_o;
    logic       sub_i;
    logic [2:0] rm_i;
    logic [2:0] frm_i;
    logic       flush_i;
    logic       norm_done_i;
    logic       align_en_o;
    logic       add_en_o;
    logic       norm_en_o;
    logic       round_en_o;
    logic [2:0] rm_o;
    logic       sub_o;
    logic       res_valid_o;
    logic       res_ready_i;
    logic       illegal_o;
    logic       busy_o;

    int   n_pass  = 0;
    int   n_total = 0;
    obs_t trace[$];

    always #5 clk_i = ~clk_i;

    fpu_add_sub_seq #(.NORM_MAX(NormMax)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .sub_i       (sub_i),
        .rm_i        (rm_i),
        .frm_i       (frm_i),
        .flush_i     (flush_i),
        .norm_done_i (norm_done_i),
        .align_en_o  (align_en_o),
        .add_en_o    (add_en_o),
        .norm_en_o   (norm_en_o),
        .round_en_o  (round_en_o),
        .rm_o        (rm_o),
        .sub_o       (sub_o),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .illegal_o   (illegal_o),
        .busy_o      (busy_o)
    );

    function automatic obs_t sample();
        obs_t o;
        o.en   = {align_en_o, add_en_o, norm_en_o, round_en_o};
        o.vld  = res_valid_o;
        o.ill  = illegal_o;
        o.rm   = rm_o;
        o.sub  = sub_o;
        o.rdy  = req_ready_o;
        o.busy = busy_o;
        return o;
    endfunction

    function automatic obs_t idle_obs(input logic [2:0] rm, input logic sub);
        obs_t o;
        o     = '0;
        o.rm  = rm;
        o.sub = sub;
        o.rdy = 1'b1;
        return o;
    endfunction

    // Timeline of one operation: d0 = first DONE cycle, dend = last DONE cycle (k=1 is T+1).
    function automatic void op_window(input logic [2:0] rm, input logic [2:0] frm,
                                      input int done_at, input int ready_at,
                                      output int n, output int d0, output int dend,
                                      output logic [2:0] eff, output logic ill);
        eff  = (rm == 3'b111) ? frm : rm;
        ill  = (eff == 3'b101) || (eff == 3'b110) || (eff == 3'b111);
        n    = (done_at == 0 || done_at > int'(NormMax)) ? int'(NormMax) : done_at;
        d0   = ill ? 1 : 4 + n;
        dend = (ready_at > d0) ? ready_at : d0;
    endfunction

    function automatic obs_t exp_obs(input int k, input logic [2:0] rm, input logic [2:0] frm,
                                     input logic sub, input int done_at, input int ready_at);
        obs_t       o;
        int         n, d0, dend;
        logic [2:0] eff;
        logic       ill;
        op_window(rm, frm, done_at, ready_at, n, d0, dend, eff, ill);
        o = idle_obs(eff, sub);
        if (k <= dend) begin
            o.rdy  = 1'b0;
            o.busy = 1'b1;
            if (k >= d0) begin
                o.vld = 1'b1;
                o.ill = ill;
            end else if (k == 1)     o.en = 4'b1000;
            else if (k == 2)         o.en = 4'b0100;
            else if (k <= 2 + n)     o.en = 4'b0010;
            else                     o.en = 4'b0001;
        end
        return o;
    endfunction

    function automatic int op_len(input logic [2:0] rm, input logic [2:0] frm,
                                  input int done_at, input int ready_at);
        int         n, d0, dend;
        logic [2:0] eff;
        logic       ill;
        op_window(rm, frm, done_at, ready_at, n, d0, dend, eff, ill);
        return dend + 2;
    endfunction

    // Issues one request from IDLE and records ncyc cycles of outputs after the accept edge.
    // norm_done_i rises in the done_at-th NORM cycle; res_ready_i rises at cycle ready_at.
    task automatic drive_op(input logic [2:0] rm, input logic [2:0] frm, input logic sub,
                            input int done_at, input int ready_at, input int ncyc);
        trace.delete();
        req_valid_i = 1'b1;
        rm_i        = rm;
        frm_i       = frm;
        sub_i       = sub;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        rm_i        = $urandom_range(0, 7);
        frm_i       = $urandom_range(0, 7);
        sub_i       = $urandom_range(0, 1);
        for (int k = 1; k <= ncyc; k++) begin
            trace.push_back(sample());
            norm_done_i = (done_at != 0) && (k >= 2 + done_at);
            res_ready_i = (k >= ready_at);
            @(posedge clk_i); #1;
        end
        norm_done_i = 1'b0;
        res_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        obs_t got;
        reset_i     = 1'b0;
        req_valid_i = 1'b0;
        sub_i       = 1'b0;
        rm_i        = 3'b000;
        frm_i       = 3'b000;
        flush_i     = 1'b0;
        norm_done_i = 1'b0;
        res_ready_i = 1'b0;
        #2;
        got = sample();
        n_total++;
        if (got !== idle_obs(3'b000, 1'b0))
            $display("FAIL reset_state got %h exp %h", got, idle_obs(3'b000, 1'b0));
        else n_pass++;
        @(posedge clk_i); #1;
        reset_i = 1'b1;
        @(posedge clk_i); #1;
        got = sample();
        n_total++;
        if (got !== idle_obs(3'b000, 1'b0))
            $display("FAIL reset_release got %h exp %h", got, idle_obs(3'b000, 1'b0));
        else n_pass++;
    endtask

    task automatic test_legal();
        obs_t e;
        drive_op(3'b000, 3'b010, 1'b1, 1, 1, op_len(3'b000, 3'b010, 1, 1));
        for (int i = 0; i < trace.size(); i++) begin
            e = exp_obs(i + 1, 3'b000, 3'b010, 1'b1, 1, 1);
            n_total++;
            if (trace[i] !== e) $display("FAIL legal k=%0d got %h exp %h", i + 1, trace[i], e);
            else n_pass++;
        end
    endtask

    task automatic test_dyn();
        obs_t e;
        logic [2:0] frm_v[2] = '{3'b011, 3'b101};
        for (int j = 0; j < 2; j++) begin
            drive_op(3'b111, frm_v[j], 1'(j), 1, 1, op_len(3'b111, frm_v[j], 1, 1));
            for (int i = 0; i < trace.size(); i++) begin
                e = exp_obs(i + 1, 3'b111, frm_v[j], 1'(j), 1, 1);
                n_total++;
                if (trace[i] !== e)
                    $display("FAIL dyn frm=%0d k=%0d got %h exp %h", frm_v[j], i + 1, trace[i], e);
                else n_pass++;
            end
        end
    endtask

    task automatic test_norm_limits();
        obs_t e;
        int   da[2] = '{0, 3};
        for (int j = 0; j < 2; j++) begin
            drive_op(3'b001, 3'b000, 1'b0, da[j], 1, op_len(3'b001, 3'b000, da[j], 1));
            for (int i = 0; i < trace.size(); i++) begin
                e = exp_obs(i + 1, 3'b001, 3'b000, 1'b0, da[j], 1);
                n_total++;
                if (trace[i] !== e)
                    $display("FAIL norm done_at=%0d k=%0d got %h exp %h", da[j], i + 1, trace[i], e);
                else n_pass++;
            end
        end
    endtask

    task automatic test_back_pressure();
        obs_t e;
        logic [2:0] rmv[2] = '{3'b100, 3'b110};
        int         rdy[2] = '{10, 5};
        for (int j = 0; j < 2; j++) begin
            drive_op(rmv[j], 3'b000, 1'b1, 2, rdy[j], op_len(rmv[j], 3'b000, 2, rdy[j]));
            for (int i = 0; i < trace.size(); i++) begin
                e = exp_obs(i + 1, rmv[j], 3'b000, 1'b1, 2, rdy[j]);
                n_total++;
                if (trace[i] !== e)
                    $display("FAIL backpressure rm=%0d k=%0d got %h exp %h", rmv[j], i + 1,
                             trace[i], e);
                else n_pass++;
            end
        end
    endtask

    task automatic test_flush();
        obs_t got;
        // Flush in the second NORM cycle.
        req_valid_i = 1'b1; rm_i = 3'b010; sub_i = 1'b0;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        repeat (3) begin @(posedge clk_i); #1; end
        n_total++;
        if (norm_en_o !== 1'b1) $display("FAIL flush_norm_pre got %b exp 1", norm_en_o);
        else n_pass++;
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            got = sample();
            n_total++;
            if (got !== idle_obs(3'b010, 1'b0))
                $display("FAIL flush_norm c=%0d got %h exp %h", i, got, idle_obs(3'b010, 1'b0));
            else n_pass++;
            @(posedge clk_i); #1;
        end
        // Flush in DONE alongside the handshake.
        req_valid_i = 1'b1; rm_i = 3'b101; sub_i = 1'b1;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        n_total++;
        if ({res_valid_o, illegal_o} !== 2'b11)
            $display("FAIL flush_done_pre got %b exp 11", {res_valid_o, illegal_o});
        else n_pass++;
        flush_i = 1'b1; res_ready_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0; res_ready_i = 1'b0;
        got = sample();
        n_total++;
        if (got !== idle_obs(3'b101, 1'b1))
            $display("FAIL flush_done got %h exp %h", got, idle_obs(3'b101, 1'b1));
        else n_pass++;
        // Flush in IDLE blocks the simultaneous request.
        req_valid_i = 1'b1; rm_i = 3'b011; sub_i = 1'b0; flush_i = 1'b1;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0; flush_i = 1'b0;
        got = sample();
        n_total++;
        if (got !== idle_obs(3'b101, 1'b1))
            $display("FAIL flush_idle got %h exp %h", got, idle_obs(3'b101, 1'b1));
        else n_pass++;
    endtask

    task automatic test_reset_mid_add();
        obs_t got;
        obs_t e;
        req_valid_i = 1'b1; rm_i = 3'b001; sub_i = 1'b1;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        @(posedge clk_i); #1;
        n_total++;
        if (add_en_o !== 1'b1) $display("FAIL reset_mid_add_pre got %b exp 1", add_en_o);
        else n_pass++;
        #2 reset_i = 1'b0;
        #1 got = sample();
        n_total++;
        if (got !== idle_obs(3'b000, 1'b0))
            $display("FAIL reset_mid_add got %h exp %h", got, idle_obs(3'b000, 1'b0));
        else n_pass++;
        reset_i = 1'b1;
        @(posedge clk_i); #1;
        got = sample();
        n_total++;
        if (got !== idle_obs(3'b000, 1'b0))
            $display("FAIL reset_mid_add_after got %h exp %h", got, idle_obs(3'b000, 1'b0));
        else n_pass++;
        drive_op(3'b011, 3'b000, 1'b0, 2, 1, op_len(3'b011, 3'b000, 2, 1));
        for (int i = 0; i < trace.size(); i++) begin
            e = exp_obs(i + 1, 3'b011, 3'b000, 1'b0, 2, 1);
            n_total++;
            if (trace[i] !== e)
                $display("FAIL post_reset_op k=%0d got %h exp %h", i + 1, trace[i], e);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        obs_t       e;
        logic [2:0] rm, frm;
        logic       sub;
        int         r, done_at, ready_at;
        for (int j = 0; j < 16; j++) begin
            rm       = $urandom_range(0, 7);
            frm      = $urandom_range(0, 7);
            sub      = $urandom_range(0, 1);
            r        = $urandom_range(0, 9);
            done_at  = (r == 9) ? 30 : r;
            ready_at = $urandom_range(1, 32);
            drive_op(rm, frm, sub, done_at, ready_at, op_len(rm, frm, done_at, ready_at));
            for (int i = 0; i < trace.size(); i++) begin
                e = exp_obs(i + 1, rm, frm, sub, done_at, ready_at);
                n_total++;
                if (trace[i] !== e)
                    $display("FAIL random op=%0d rm=%0d frm=%0d k=%0d got %h exp %h", j, rm, frm,
                             i + 1, trace[i], e);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_legal();
        test_dyn();
        test_norm_limits();
        test_back_pressure();
        test_flush();
        test_reset_mid_add();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
